// File: rtl/tb_pzcorebus_request_throttle.sv
// ---------------------------------------------------------------------------
// tb_pzcorebus_request_throttle
//
// Request-shaping stage placed directly in front of the corebus slave BFM.
// It limits the number of in-flight non-posted commands, holds write data
// off until its command has been accepted (command-before-data ordering) and
// forces a programmable idle gap after every accepted command. Payloads pass
// through combinationally; only the valid/accept handshakes are gated.
// Responses are not touched; they are only observed to retire credits.
//
// Command encoding (mirrors pzcorebus_command_type):
//   READ 4'b0001, WRITE 4'b0100, WRITE_NON_POSTED 4'b0101,
//   FULL_WRITE 4'b0110, FULL_WRITE_NON_POSTED 4'b0111, BROADCAST 4'b1100
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_cmd_gap             idle cycles forced after each command ack
//   i_mcmd_* / o_scmd_accept        upstream command channel
//   o_mcmd_* / i_scmd_accept        downstream command channel
//   i_mdata_* / o_sdata_accept      upstream write-data channel
//   o_mdata_* / i_sdata_accept      downstream write-data channel
//   i_sresp_valid, i_sresp_last, i_mresp_accept   monitored response handshake
//   o_outstanding         current in-flight non-posted command count
//   o_error               sticky protocol error flag
// ---------------------------------------------------------------------------
module tb_pzcorebus_request_throttle #(
  parameter int ID_WIDTH        = 8,
  parameter int ADDRESS_WIDTH   = 64,
  parameter int LENGTH_WIDTH    = 8,
  parameter int DATA_WIDTH      = 128,
  parameter int MAX_OUTSTANDING = 16,
  parameter int GAP_WIDTH       = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [GAP_WIDTH-1:0]      i_cmd_gap,
  input  logic                      i_mcmd_valid,
  output logic                      o_scmd_accept,
  input  logic [3:0]                i_mcmd,
  input  logic [ID_WIDTH-1:0]       i_mid,
  input  logic [ADDRESS_WIDTH-1:0]  i_maddr,
  input  logic [LENGTH_WIDTH-1:0]   i_mlength,
  output logic                      o_mcmd_valid,
  output logic [3:0]                o_mcmd,
  output logic [ID_WIDTH-1:0]       o_mid,
  output logic [ADDRESS_WIDTH-1:0]  o_maddr,
  output logic [LENGTH_WIDTH-1:0]   o_mlength,
  input  logic                      i_scmd_accept,
  input  logic                      i_mdata_valid,
  output logic                      o_sdata_accept,
  input  logic [DATA_WIDTH-1:0]     i_mdata,
  input  logic [DATA_WIDTH/8-1:0]   i_mdata_byteen,
  input  logic                      i_mdata_last,
  output logic                      o_mdata_valid,
  output logic [DATA_WIDTH-1:0]     o_mdata,
  output logic [DATA_WIDTH/8-1:0]   o_mdata_byteen,
  output logic                      o_mdata_last,
  input  logic                      i_sdata_accept,
  input  logic                      i_sresp_valid,
  input  logic                      i_sresp_last,
  input  logic                      i_mresp_accept,
  output logic [7:0]                o_outstanding,
  output logic                      o_error
);

  localparam logic [3:0] CMD_READ                  = 4'b0001;
  localparam logic [3:0] CMD_WRITE                 = 4'b0100;
  localparam logic [3:0] CMD_WRITE_NON_POSTED      = 4'b0101;
  localparam logic [3:0] CMD_FULL_WRITE            = 4'b0110;
  localparam logic [3:0] CMD_FULL_WRITE_NON_POSTED = 4'b0111;
  localparam logic [3:0] CMD_BROADCAST             = 4'b1100;

  localparam logic [7:0]  MAX_COUNT   = 8'(MAX_OUTSTANDING);
  // Upstream data may sit valid in CMD for this many cycles before the
  // missing-last condition is flagged on the next one.
  localparam logic [10:0] STALL_LIMIT = 11'd1024;

  typedef enum logic {
    CMD,
    DATA
  } state_e;

  function automatic logic has_data(input logic [3:0] cmd);
    case (cmd)
      CMD_WRITE, CMD_WRITE_NON_POSTED, CMD_FULL_WRITE,
      CMD_FULL_WRITE_NON_POSTED, CMD_BROADCAST: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  function automatic logic is_non_posted(input logic [3:0] cmd);
    case (cmd)
      CMD_READ, CMD_WRITE_NON_POSTED, CMD_FULL_WRITE_NON_POSTED: return 1'b1;
      default:                                                   return 1'b0;
    endcase
  endfunction

  state_e               state;
  logic [GAP_WIDTH-1:0] gap;
  logic [7:0]           outstanding;
  logic [10:0]          stall_count;
  logic                 error;

  logic cmd_non_posted;
  logic cmd_with_data;
  logic cmd_open;
  logic data_open;
  logic cmd_ack;
  logic data_last_ack;
  logic resp_done;
  logic count_inc;
  logic count_dec;

  assign cmd_non_posted = is_non_posted(i_mcmd);
  assign cmd_with_data  = has_data(i_mcmd);

  // i_rst_n is folded into the gates so every valid/accept output reads 0
  // while reset is held, even though the registered state already allows
  // a command.
  assign cmd_open  = i_rst_n && (state == CMD) && (gap == '0) &&
                     !(cmd_non_posted && (outstanding == MAX_COUNT));
  assign data_open = i_rst_n && (state == DATA);

  assign o_mcmd_valid   = i_mcmd_valid && cmd_open;
  assign o_scmd_accept  = i_scmd_accept && cmd_open;
  assign o_mcmd         = i_mcmd;
  assign o_mid          = i_mid;
  assign o_maddr        = i_maddr;
  assign o_mlength      = i_mlength;

  assign o_mdata_valid  = i_mdata_valid && data_open;
  assign o_sdata_accept = i_sdata_accept && data_open;
  assign o_mdata        = i_mdata;
  assign o_mdata_byteen = i_mdata_byteen;
  assign o_mdata_last   = i_mdata_last;

  assign cmd_ack       = o_mcmd_valid && i_scmd_accept;
  assign data_last_ack = o_mdata_valid && i_sdata_accept && i_mdata_last;
  assign resp_done     = i_sresp_valid && i_mresp_accept && i_sresp_last;

  // A response with nothing outstanding is an error and must not wrap the
  // counter, so the decrement is suppressed at zero.
  assign count_inc = cmd_ack && cmd_non_posted;
  assign count_dec = resp_done && (outstanding != 8'd0);

  assign o_outstanding = outstanding;
  assign o_error       = error;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= CMD;
      gap         <= '0;
      outstanding <= 8'd0;
      stall_count <= 11'd0;
      error       <= 1'b0;
    end else begin
      case (state)
        CMD:     if (cmd_ack && cmd_with_data) state <= DATA;
        DATA:    if (data_last_ack)            state <= CMD;
        default:                               state <= CMD;
      endcase

      // Gap runs concurrently with the data phase.
      if (cmd_ack) begin
        gap <= i_cmd_gap;
      end else if (gap != '0) begin
        gap <= gap - GAP_WIDTH'(1);
      end

      if (count_inc && !count_dec) begin
        outstanding <= outstanding + 8'd1;
      end else if (!count_inc && count_dec) begin
        outstanding <= outstanding - 8'd1;
      end

      if (resp_done && (outstanding == 8'd0)) begin
        error <= 1'b1;
      end

      if ((state == CMD) && i_mdata_valid) begin
        if (stall_count == STALL_LIMIT) begin
          error <= 1'b1;
        end else begin
          stall_count <= stall_count + 11'd1;
        end
      end else begin
        stall_count <= 11'd0;
      end
    end
  end

endmodule

// File: tb/tb_tb_pzcorebus_request_throttle.sv
// ---------------------------------------------------------------------------
// tb_tb_pzcorebus_request_throttle
//
// Directed bench for tb_pzcorebus_request_throttle with MAX_OUTSTANDING=2.
// A per-cycle vector table drives the credit, ordering and error scenarios;
// hand-written sequences cover the idle gap, reset mid-burst and the
// missing-last watchdog.
// ---------------------------------------------------------------------------
module tb_tb_pzcorebus_request_throttle;

  localparam logic [3:0] READ    = 4'b0001;
  localparam logic [3:0] WRITE   = 4'b0100;
  localparam logic [3:0] WRITENP = 4'b0101;
  localparam logic [3:0] BCAST   = 4'b1100;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    cmd_gap;
  logic          mcmd_valid_in;
  logic          scmd_accept_out;
  logic [3:0]    mcmd_in;
  logic [7:0]    mid_in;
  logic [63:0]   maddr_in;
  logic [7:0]    mlength_in;
  logic          mcmd_valid_out;
  logic [3:0]    mcmd_out;
  logic [7:0]    mid_out;
  logic [63:0]   maddr_out;
  logic [7:0]    mlength_out;
  logic          scmd_accept_in;
  logic          mdata_valid_in;
  logic          sdata_accept_out;
  logic [127:0]  mdata_in;
  logic [15:0]   byteen_in;
  logic          mdata_last_in;
  logic          mdata_valid_out;
  logic [127:0]  mdata_out;
  logic [15:0]   byteen_out;
  logic          mdata_last_out;
  logic          sdata_accept_in;
  logic          sresp_valid;
  logic          sresp_last;
  logic          mresp_accept;
  logic [7:0]    outstanding;
  logic          error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tb_pzcorebus_request_throttle #(
    .ID_WIDTH(8), .ADDRESS_WIDTH(64), .LENGTH_WIDTH(8), .DATA_WIDTH(128),
    .MAX_OUTSTANDING(2), .GAP_WIDTH(4)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cmd_gap(cmd_gap),
    .i_mcmd_valid(mcmd_valid_in), .o_scmd_accept(scmd_accept_out),
    .i_mcmd(mcmd_in), .i_mid(mid_in), .i_maddr(maddr_in), .i_mlength(mlength_in),
    .o_mcmd_valid(mcmd_valid_out), .o_mcmd(mcmd_out), .o_mid(mid_out),
    .o_maddr(maddr_out), .o_mlength(mlength_out), .i_scmd_accept(scmd_accept_in),
    .i_mdata_valid(mdata_valid_in), .o_sdata_accept(sdata_accept_out),
    .i_mdata(mdata_in), .i_mdata_byteen(byteen_in), .i_mdata_last(mdata_last_in),
    .o_mdata_valid(mdata_valid_out), .o_mdata(mdata_out),
    .o_mdata_byteen(byteen_out), .o_mdata_last(mdata_last_out),
    .i_sdata_accept(sdata_accept_in), .i_sresp_valid(sresp_valid),
    .i_sresp_last(sresp_last), .i_mresp_accept(mresp_accept),
    .o_outstanding(outstanding), .o_error(error)
  );

  typedef struct {
    logic       cv;
    logic [3:0] cmd;
    logic       dv;
    logic       dl;
    logic       resp;
    logic       e_mv;
    logic       e_sa;
    logic       e_md;
    logic       e_sd;
    logic [7:0] e_out;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic cv, input logic [3:0] cmd, input logic dv,
                     input logic dl, input logic resp, input logic e_mv,
                     input logic e_sa, input logic e_md, input logic e_sd,
                     input logic [7:0] e_out, input logic e_err);
    vec_t v;
    v.cv = cv; v.cmd = cmd; v.dv = dv; v.dl = dl; v.resp = resp;
    v.e_mv = e_mv; v.e_sa = e_sa; v.e_md = e_md; v.e_sd = e_sd;
    v.e_out = e_out; v.e_err = e_err;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mcmd_valid_in = 1'b0; mcmd_in = 4'b0000; mdata_valid_in = 1'b0;
    mdata_last_in = 1'b0; sresp_valid = 1'b0; sresp_last = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int acks[$];
    // Table: cv cmd dv dl resp | mv sa md sd out err
    add(0, 4'b0, 0, 0, 0,  0, 1, 0, 0, 0, 0);
    add(1, READ, 0, 0, 0,  1, 1, 0, 0, 0, 0);   // READ 1
    add(1, READ, 0, 0, 0,  1, 1, 0, 0, 1, 0);   // READ 2, back to back
    add(1, READ, 0, 0, 0,  0, 0, 0, 0, 2, 0);   // full: blocked
    add(1, READ, 0, 0, 1,  0, 0, 0, 0, 2, 0);   // resp_done, no bypass
    add(1, READ, 0, 0, 0,  1, 1, 0, 0, 1, 0);   // unblocked next cycle
    add(0, 4'b0, 0, 0, 0,  0, 1, 0, 0, 2, 0);
    add(0, 4'b0, 0, 0, 1,  0, 1, 0, 0, 2, 0);   // retire to 1
    add(1, READ, 0, 0, 1,  1, 1, 0, 0, 1, 0);   // inc+dec same cycle
    add(0, 4'b0, 0, 0, 0,  0, 1, 0, 0, 1, 0);   // still 1
    add(0, 4'b0, 0, 0, 1,  0, 1, 0, 0, 1, 0);
    add(0, 4'b0, 0, 0, 0,  0, 1, 0, 0, 0, 0);
    add(0, 4'b0, 1, 0, 0,  0, 1, 0, 0, 0, 0);   // early data held off x3
    add(0, 4'b0, 1, 0, 0,  0, 1, 0, 0, 0, 0);
    add(0, 4'b0, 1, 0, 0,  0, 1, 0, 0, 0, 0);
    add(1, WRITE, 1, 0, 0, 1, 1, 0, 0, 0, 0);   // WRITE ack, data still held
    add(0, 4'b0, 1, 0, 0,  0, 0, 1, 1, 0, 0);   // beat 1
    add(0, 4'b0, 1, 0, 0,  0, 0, 1, 1, 0, 0);   // beat 2
    add(0, 4'b0, 1, 0, 0,  0, 0, 1, 1, 0, 0);   // beat 3
    add(1, READ, 1, 1, 0,  0, 0, 1, 1, 0, 0);   // beat 4 last, READ waits
    add(1, READ, 0, 0, 0,  1, 1, 0, 0, 0, 0);   // READ right after last ack
    add(0, 4'b0, 0, 0, 0,  0, 1, 0, 0, 1, 0);
    add(0, 4'b0, 0, 0, 1,  0, 1, 0, 0, 1, 0);
    add(1, WRITENP, 1, 1, 0, 1, 1, 0, 0, 0, 0); // non-posted write
    add(0, 4'b0, 1, 1, 0,  0, 0, 1, 1, 1, 0);
    add(1, BCAST, 1, 1, 0, 1, 1, 0, 0, 1, 0);   // posted with data
    add(0, 4'b0, 1, 1, 0,  0, 0, 1, 1, 1, 0);
    add(0, 4'b0, 0, 0, 1,  0, 1, 0, 0, 1, 0);
    add(0, 4'b0, 0, 0, 0,  0, 1, 0, 0, 0, 0);
    add(0, 4'b0, 0, 0, 1,  0, 1, 0, 0, 0, 0);   // resp with count 0
    add(0, 4'b0, 0, 0, 0,  0, 1, 0, 0, 0, 1);   // error set, count 0
    add(1, READ, 0, 0, 0,  1, 1, 0, 0, 0, 1);
    add(0, 4'b0, 0, 0, 0,  0, 1, 0, 0, 1, 1);   // error sticky
    add(0, 4'b0, 0, 0, 1,  0, 1, 0, 0, 1, 1);
    add(0, 4'b0, 0, 0, 0,  0, 1, 0, 0, 0, 1);

    // Reset state with inputs active
    rst_n = 1'b0;
    cmd_gap = 4'd0; mid_in = 8'h5a; maddr_in = 64'h0123_4567_89ab_cdef;
    mlength_in = 8'd3; mdata_in = {4{32'hdead_beef}}; byteen_in = 16'hffff;
    scmd_accept_in = 1'b1; sdata_accept_in = 1'b1; mresp_accept = 1'b1;
    sresp_valid = 1'b0; sresp_last = 1'b0;
    mcmd_valid_in = 1'b1; mcmd_in = READ; mdata_valid_in = 1'b1; mdata_last_in = 1'b0;
    #3;
    check("reset mcmd_valid", 128'(mcmd_valid_out), 128'd0);
    check("reset scmd_accept", 128'(scmd_accept_out), 128'd0);
    check("reset mdata_valid", 128'(mdata_valid_out), 128'd0);
    check("reset sdata_accept", 128'(sdata_accept_out), 128'd0);
    check("reset outstanding", 128'(outstanding), 128'd0);
    check("reset error", 128'(error), 128'd0);
    do_reset();

    foreach (vecs[i]) begin
      mcmd_valid_in = vecs[i].cv; mcmd_in = vecs[i].cmd;
      mdata_valid_in = vecs[i].dv; mdata_last_in = vecs[i].dl;
      sresp_valid = vecs[i].resp; sresp_last = vecs[i].resp;
      #3;
      check($sformatf("vec%0d mcmd_valid", i), 128'(mcmd_valid_out), 128'(vecs[i].e_mv));
      check($sformatf("vec%0d scmd_accept", i), 128'(scmd_accept_out), 128'(vecs[i].e_sa));
      check($sformatf("vec%0d mdata_valid", i), 128'(mdata_valid_out), 128'(vecs[i].e_md));
      check($sformatf("vec%0d sdata_accept", i), 128'(sdata_accept_out), 128'(vecs[i].e_sd));
      check($sformatf("vec%0d outstanding", i), 128'(outstanding), 128'(vecs[i].e_out));
      check($sformatf("vec%0d error", i), 128'(error), 128'(vecs[i].e_err));
      step();
    end

    // Gap of 3: continuous posted 1-beat WRITEs ack every 4 cycles
    do_reset();
    cmd_gap = 4'd3;
    mcmd_valid_in = 1'b1; mcmd_in = WRITE; mdata_valid_in = 1'b1; mdata_last_in = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #3;
      if (mcmd_valid_out && scmd_accept_in) acks.push_back(c);
      step();
    end
    check("gap ack count", 128'(acks.size()), 128'd5);
    for (int k = 1; k < acks.size(); k++)
      check($sformatf("gap spacing %0d", k), 128'(acks[k] - acks[k-1]), 128'd4);
    idle_inputs();
    cmd_gap = 4'd0;

    // Reset mid-burst, beat 2 of 4
    do_reset();
    mcmd_valid_in = 1'b1; mcmd_in = READ;
    step();
    mcmd_in = WRITE;
    #3;
    check("burst cmd ack", 128'(mcmd_valid_out), 128'd1);
    step();
    mcmd_valid_in = 1'b0; mdata_valid_in = 1'b1; mdata_last_in = 1'b0;
    #1;
    check("burst beat1 valid", 128'(mdata_valid_out), 128'd1);
    check("mdata passthrough", mdata_out, {4{32'hdead_beef}});
    step();
    #1;
    check("burst beat2 valid", 128'(mdata_valid_out), 128'd1);
    check("burst outstanding", 128'(outstanding), 128'd1);
    rst_n = 1'b0;
    mcmd_valid_in = 1'b1; mcmd_in = READ;
    #1;
    check("midrst mdata_valid", 128'(mdata_valid_out), 128'd0);
    check("midrst sdata_accept", 128'(sdata_accept_out), 128'd0);
    check("midrst mcmd_valid", 128'(mcmd_valid_out), 128'd0);
    check("midrst scmd_accept", 128'(scmd_accept_out), 128'd0);
    check("midrst outstanding", 128'(outstanding), 128'd0);
    step();
    rst_n = 1'b1;
    mdata_valid_in = 1'b0;
    maddr_in = 64'hfeed_0000_0000_1000;
    #2;
    check("post-rst read valid", 128'(mcmd_valid_out), 128'd1);
    check("post-rst read accept", 128'(scmd_accept_out), 128'd1);
    check("maddr passthrough", 128'(maddr_out), 128'(64'hfeed_0000_0000_1000));
    step();
    mcmd_valid_in = 1'b0;
    #2;
    check("post-rst outstanding", 128'(outstanding), 128'd1);

    // Missing mdata_last: data valid in CMD for more than 1024 cycles
    do_reset();
    mdata_valid_in = 1'b1; mdata_last_in = 1'b0;
    repeat (1024) step();
    check("stall 1024 error", 128'(error), 128'd0);
    check("stall data held", 128'(mdata_valid_out), 128'd0);
    step();
    check("stall 1025 error", 128'(error), 128'd1);
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
